// File: rtl/tiny_pkg.sv
// Shared definitions for the TinyRAM block copier and the TinyRAM itself.
// Holds the FSM state encoding, mode constants and default bus widths.
package tiny_pkg;

  localparam int TINY_ADDR_W = 8;
  localparam int TINY_DATA_W = 8;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } copier_state_t;

endpackage

// File: rtl/tiny_mem_copier_if.sv
// TinyRAM read/write port as seen by an initiator (master) and the RAM (slave).
// Read data is combinational: valid in the same cycle as mem_read.
interface tiny_mem_copier_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) ();

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_read,
    output mem_write,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/tiny_ram.sv
// TinyRAM: single-port RAM with synchronous write and combinational read.
// No reset on the array so it maps onto distributed memory.
module tiny_ram
  import tiny_pkg::*;
#(
  parameter int ADDR_W = TINY_ADDR_W,
  parameter int DATA_W = TINY_DATA_W
) (
  input  logic             clk,
  tiny_mem_copier_if.slave bus
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (bus.mem_write) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  assign bus.mem_rdata = mem[bus.mem_addr];

endmodule

// File: rtl/tiny_mem_copier.sv
// Block copy / block fill engine driving the TinyRAM port as bus master.
// All outputs are registered, so no input reaches an output combinationally.
module tiny_mem_copier
  import tiny_pkg::*;
#(
  parameter int ADDR_W = TINY_ADDR_W,
  parameter int DATA_W = TINY_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] fill_val,
  output logic              busy,
  output logic              done,
  tiny_mem_copier_if.master mem
);

  copier_state_t     state;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [ADDR_W-1:0] remaining;
  logic [DATA_W-1:0] fill_reg;
  logic              mode_reg;
  logic              read_reg;
  logic              write_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;

  assign mem.mem_read  = read_reg;
  assign mem.mem_write = write_reg;
  assign mem.mem_addr  = addr_reg;
  assign mem.mem_wdata = wdata_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      fill_reg  <= '0;
      mode_reg  <= MODE_COPY;
      busy      <= 1'b0;
      done      <= 1'b0;
      read_reg  <= 1'b0;
      write_reg <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      // Idle outputs by default; each surviving transition overrides them,
      // so abort and DONE fall straight back to the idle bus state.
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      read_reg  <= 1'b0;
      write_reg <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;

      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            src_ptr   <= src;
            dst_ptr   <= dst;
            remaining <= len;
            fill_reg  <= fill_val;
            mode_reg  <= mode;
            busy      <= 1'b1;
            if (len == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else if (mode == MODE_FILL) begin
              state     <= ST_WRITE;
              write_reg <= 1'b1;
              addr_reg  <= dst;
              wdata_reg <= fill_val;
            end else begin
              state    <= ST_READ;
              read_reg <= 1'b1;
              addr_reg <= src;
            end
          end
        end

        ST_READ: begin
          if (!abort) begin
            // The write-data register doubles as the copy buffer.
            src_ptr   <= src_ptr + 1'b1;
            state     <= ST_WRITE;
            busy      <= 1'b1;
            write_reg <= 1'b1;
            addr_reg  <= dst_ptr;
            wdata_reg <= mem.mem_rdata;
          end
        end

        ST_WRITE: begin
          if (!abort) begin
            dst_ptr   <= dst_ptr + 1'b1;
            remaining <= remaining - 1'b1;
            busy      <= 1'b1;
            if (remaining == ADDR_W'(1)) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else if (mode_reg == MODE_COPY) begin
              state    <= ST_READ;
              read_reg <= 1'b1;
              addr_reg <= src_ptr;
            end else begin
              state     <= ST_WRITE;
              write_reg <= 1'b1;
              addr_reg  <= dst_ptr + 1'b1;
              wdata_reg <= fill_reg;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tiny_mem_copier.sv
// Bench for tiny_mem_copier against the real TinyRAM, with a byte-serial
// reference model feeding read/write scoreboards and a protocol monitor.
module tb_tiny_mem_copier;
  import tiny_pkg::*;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          mode = 1'b0;
  logic [AW-1:0] src = '0;
  logic [AW-1:0] dst = '0;
  logic [AW-1:0] len = '0;
  logic [DW-1:0] fill_val = '0;
  logic          busy;
  logic          done;

  logic          tb_sel = 1'b0;
  logic          tb_we = 1'b0;
  logic [AW-1:0] tb_addr = '0;
  logic [DW-1:0] tb_wdata = '0;

  always #5 clk = ~clk;

  tiny_mem_copier_if #(.ADDR_W(AW), .DATA_W(DW)) cp_bus ();
  tiny_mem_copier_if #(.ADDR_W(AW), .DATA_W(DW)) ram_bus ();

  // Port mux in front of the RAM so the bench can preload it.
  assign ram_bus.mem_read  = tb_sel ? 1'b0     : cp_bus.mem_read;
  assign ram_bus.mem_write = tb_sel ? tb_we    : cp_bus.mem_write;
  assign ram_bus.mem_addr  = tb_sel ? tb_addr  : cp_bus.mem_addr;
  assign ram_bus.mem_wdata = tb_sel ? tb_wdata : cp_bus.mem_wdata;
  assign cp_bus.mem_rdata  = ram_bus.mem_rdata;

  tiny_mem_copier #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .mode     (mode),
    .src      (src),
    .dst      (dst),
    .len      (len),
    .fill_val (fill_val),
    .busy     (busy),
    .done     (done),
    .mem      (cp_bus)
  );

  tiny_ram #(.ADDR_W(AW), .DATA_W(DW)) u_ram (
    .clk (clk),
    .bus (ram_bus)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic done_prev = 1'b0;
  logic [DW-1:0] model [256];
  logic [AW-1:0] rd_q [$];
  logic [AW+DW-1:0] wr_q [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: forward, byte-serial transfer; only the first nbytes happen.
  task automatic model_xfer(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input logic [DW-1:0] f, input int nbytes);
    logic [AW-1:0] sa, da;
    logic [DW-1:0] b;
    for (int i = 0; i < nbytes; i++) begin
      sa = s + AW'(i);
      da = d + AW'(i);
      if (m == MODE_COPY) begin
        rd_q.push_back(sa);
        b = model[sa];
      end else begin
        b = f;
      end
      model[da] = b;
      wr_q.push_back({da, b});
    end
  endtask

  task automatic check_image(input string name);
    int mm = 0;
    int first = -1;
    for (int a = 0; a < 256; a++) begin
      if (u_ram.mem[a] != model[a]) begin
        mm++;
        if (first < 0) first = a;
      end
    end
    chk($sformatf("%s mem_mismatches(first_addr=%0d)", name, first), mm, 0);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    tb_sel = 1'b1; tb_we = 1'b1; tb_addr = a; tb_wdata = d;
    @(posedge clk);
    #1 tb_we = 1'b0; tb_sel = 1'b0;
    model[a] = d;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("rd_wr_exclusive", int'(cp_bus.mem_read & cp_bus.mem_write), 0);
      if (done) begin
        done_cnt++;
        chk("done_single_cycle", int'(done_prev), 0);
      end
      done_prev = done;
      if (cp_bus.mem_read) begin
        chk("read_expected", int'(rd_q.size() != 0), 1);
        if (rd_q.size() != 0) chk("read_addr", int'(cp_bus.mem_addr), int'(rd_q.pop_front()));
      end
      if (cp_bus.mem_write) begin
        chk("write_expected", int'(wr_q.size() != 0), 1);
        if (wr_q.size() != 0)
          chk("write_addr_data", int'({cp_bus.mem_addr, cp_bus.mem_wdata}), int'(wr_q.pop_front()));
      end
    end else begin
      done_prev = 1'b0;
    end
  end

  typedef struct {
    string         name;
    logic          m;
    logic [AW-1:0] s;
    logic [AW-1:0] d;
    logic [AW-1:0] l;
    logic [DW-1:0] f;
    int            exp_edges;
    bit            poke;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n;
    int dc;

    vecs[0] = '{"copy4",      MODE_COPY, 8'h10, 8'h40, 8'd4,  8'h00, 8,  1'b0};
    vecs[1] = '{"fill3",      MODE_FILL, 8'h00, 8'h80, 8'd3,  8'h5A, 3,  1'b0};
    vecs[2] = '{"copy_wrap",  MODE_COPY, 8'hFE, 8'h20, 8'd3,  8'h00, 6,  1'b0};
    vecs[3] = '{"len0",       MODE_COPY, 8'h10, 8'h60, 8'd0,  8'h99, 0,  1'b0};
    vecs[4] = '{"overlap",    MODE_COPY, 8'h30, 8'h31, 8'd4,  8'h00, 8,  1'b0};
    vecs[5] = '{"fill_wrap",  MODE_FILL, 8'h00, 8'hF0, 8'd32, 8'hC3, 32, 1'b1};
    vecs[6] = '{"copy_down",  MODE_COPY, 8'h50, 8'h4E, 8'd6,  8'h00, 12, 1'b1};

    #1;
    chk("reset_busy",  int'(busy), 0);
    chk("reset_done",  int'(done), 0);
    chk("reset_read",  int'(cp_bus.mem_read), 0);
    chk("reset_write", int'(cp_bus.mem_write), 0);
    chk("reset_addr",  int'(cp_bus.mem_addr), 0);
    chk("reset_wdata", int'(cp_bus.mem_wdata), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int a = 0; a < 256; a++) preload(AW'(a), DW'(a) ^ 8'h5C);
    preload(8'h10, 8'hAA); preload(8'h11, 8'hBB);
    preload(8'h12, 8'hCC); preload(8'h13, 8'hDD);
    preload(8'h30, 8'h77);
    preload(8'hFE, 8'h11); preload(8'hFF, 8'h22); preload(8'h00, 8'h33);

    for (int v = 0; v < 7; v++) begin
      model_xfer(vecs[v].m, vecs[v].s, vecs[v].d, vecs[v].f, int'(vecs[v].l));
      @(negedge clk);
      start = 1'b1; mode = vecs[v].m; src = vecs[v].s; dst = vecs[v].d;
      len = vecs[v].l; fill_val = vecs[v].f;
      @(posedge clk);
      #1 start = 1'b0;
      // Scramble inputs: the transfer must run from latched copies.
      mode = ~vecs[v].m; src = AW'($urandom); dst = AW'($urandom);
      len = AW'($urandom); fill_val = DW'($urandom);
      @(negedge clk);
      n = 0;
      while (!done && n < 600) begin
        start = vecs[v].poke && (n == 1);
        @(negedge clk);
        n++;
      end
      start = 1'b0;
      chk({vecs[v].name, " done_seen"}, int'(done), 1);
      chk({vecs[v].name, " done_latency"}, n, vecs[v].exp_edges);
      @(negedge clk);
      chk({vecs[v].name, " busy_after"}, int'(busy), 0);
      chk({vecs[v].name, " rd_q_drained"}, rd_q.size(), 0);
      chk({vecs[v].name, " wr_q_drained"}, wr_q.size(), 0);
      check_image(vecs[v].name);
      $display("vector %s mode=%0d src=%02h dst=%02h len=%0d latency=%0d", vecs[v].name,
               vecs[v].m, vecs[v].s, vecs[v].d, vecs[v].l, n);
    end

    // abort in IDLE blocks a simultaneous start
    dc = done_cnt;
    @(negedge clk);
    start = 1'b1; abort = 1'b1; mode = MODE_FILL; dst = 8'h70; len = 8'd2; fill_val = 8'hEE;
    @(posedge clk);
    #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("idle_abort busy", int'(busy), 0);
    chk("idle_abort write", int'(cp_bus.mem_write), 0);
    $display("sequence idle_abort busy=%0d", busy);

    // abort on the 3rd WRITE of a 10-byte fill
    model_xfer(MODE_FILL, 8'h00, 8'h90, 8'h3C, 3);
    @(negedge clk);
    start = 1'b1; mode = MODE_FILL; dst = 8'h90; len = 8'd10; fill_val = 8'h3C;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("abort third_write_active", int'(cp_bus.mem_write), 1);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort busy_next", int'(busy), 0);
    chk("abort write_next", int'(cp_bus.mem_write), 0);
    repeat (4) @(negedge clk);
    chk("abort no_done", done_cnt, dc);
    chk("abort wr_q_drained", wr_q.size(), 0);
    check_image("abort");
    $display("sequence abort_fill written=3 done_pulses=%0d", done_cnt - dc);

    // asynchronous reset in the middle of a copy (during the 2nd READ)
    model_xfer(MODE_COPY, 8'h00, 8'hA0, 8'h00, 1);
    rd_q.push_back(8'h01);
    @(negedge clk);
    start = 1'b1; mode = MODE_COPY; src = 8'h00; dst = 8'hA0; len = 8'd5;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("reset_mid read_active", int'(cp_bus.mem_read), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_mid read", int'(cp_bus.mem_read), 0);
    chk("reset_mid write", int'(cp_bus.mem_write), 0);
    chk("reset_mid busy", int'(busy), 0);
    chk("reset_mid addr", int'(cp_bus.mem_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_mid no_done", done_cnt, dc);
    chk("reset_mid rd_q_drained", rd_q.size(), 0);
    chk("reset_mid wr_q_drained", wr_q.size(), 0);
    check_image("reset_mid");
    $display("sequence reset_mid_copy busy=%0d", busy);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tiny_mem_copier.md
Name: tiny_mem_copier

Overview:
- Bus initiator that drives the TinyRAM read/write port: the master side of that interface.
- Performs block copy (memory-to-memory) or block fill (constant-to-memory) over an 8-bit address space.
- The core controls it with a start/busy/done handshake.
- Sits between the core's control logic and the RAM port, muxed with the core's own accesses; the mux is outside this block.

Parameters:
- ADDR_W, 8, address width; pointers wrap modulo 2^ADDR_W.
- DATA_W, 8, data width of the RAM port.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a transfer; sampled only in IDLE.
- abort  in  1  cancel the transfer in progress.
- mode  in  1  0 = copy, 1 = fill.
- src  in  ADDR_W  copy source start address.
- dst  in  ADDR_W  destination start address.
- len  in  ADDR_W  byte count; 0 = empty transfer.
- fill_val  in  DATA_W  fill byte.
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- done  out  1  one-cycle completion pulse.
- mem_read  out  1  RAM read strobe.
- mem_write  out  1  RAM write strobe.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; combinational, valid in the same cycle as mem_read.

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE.
  - busy, done, mem_read, mem_write = 0.
  - mem_addr, mem_wdata = 0.
  - All internal registers = 0.
- States: IDLE, READ, WRITE, DONE.
- Memory outputs decode from state and internal registers only; there is no combinational path from any input to any output.
- mem_read and mem_write are never high in the same cycle.
- IDLE:
  - Outputs idle (all strobes 0, addr/wdata 0).
  - On start=1 and abort=0, latch src_ptr=src, dst_ptr=dst, remaining=len, fill_reg=fill_val, mode_reg=mode.
  - Next state: len==0 -> DONE; mode=0 -> READ; mode=1 -> WRITE.
  - start while busy is ignored; inputs are not re-sampled mid-transfer.
- READ (copy only):
  - mem_read=1, mem_addr=src_ptr.
  - At the edge: data_buf <= mem_rdata, src_ptr <= src_ptr+1 (wraps), next = WRITE.
- WRITE:
  - mem_write=1, mem_addr=dst_ptr.
  - mem_wdata = data_buf (copy) or fill_reg (fill).
  - At the edge: dst_ptr <= dst_ptr+1 (wraps), remaining <= remaining-1.
  - If remaining==1 -> DONE; else copy -> READ, fill -> WRITE.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- Timing: start accepted at edge k.
  - Copy of N bytes: 2N access cycles, then done asserted in cycle k+2N+1.
  - Fill of N bytes: N access cycles, then done in cycle k+N+1.
  - len=0: done in cycle k+1, with no memory access.
- Overlap: the copy is forward and byte-serial, so each byte is written before the next is read.
  - dst = src+1 replicates byte src across the whole range. This is defined behaviour.
  - dst < src is a correct move.
- Wrap-around: pointers crossing 0xFF continue at 0x00.
- Abort:
  - abort=1 in READ, WRITE or DONE -> IDLE at the next edge.
  - The access in the current cycle still completes.
  - No done pulse follows; writes already made stay in memory.
  - abort in IDLE blocks start in the same cycle.
- Reset mid-transfer: immediate return to IDLE; strobes drop asynchronously; no done.
- Maximum transfer is 2^ADDR_W-1 bytes.

Decomposition:
- Shared package tiny_pkg holds:
  - the state enum (IDLE/READ/WRITE/DONE)
  - the mode constants MODE_COPY=0, MODE_FILL=1
  - ADDR_W/DATA_W defaults, shared with TinyRAM.
- Single module; no sub-module is warranted.
- The bench instantiates the real TinyRAM as the responder.

Test Plan:
- Copy: RAM[0x10..0x13]=AA,BB,CC,DD; start mode=0 src=0x10 dst=0x40 len=4 -> RAM[0x40..0x43]=AA,BB,CC,DD; done high exactly at cycle k+9; busy low afterward.
- Fill: mode=1 dst=0x80 len=3 fill_val=0x5A -> RAM[0x80..0x82]=5A, RAM[0x83] unchanged; done at k+4; mem_read never asserted.
- Wrap and len=0: copy src=0xFE dst=0x20 len=3 -> reads 0xFE,0xFF,0x00 in that order; separately, len=0 -> done at k+1 with no strobes.
- Overlap: RAM[0x30]=0x77; copy src=0x30 dst=0x31 len=4 -> RAM[0x31..0x34]=0x77.
- Abort: fill len=10, abort asserted on the 3rd WRITE cycle -> exactly 3 bytes written, state IDLE next cycle, no done pulse. Repeat with async rst_n low mid-copy -> strobes drop immediately, outputs at reset values.
- Protocol checker throughout all tests:
  - mem_read and mem_write never both high.
  - start during busy is ignored.
  - done is always a single-cycle pulse.
